// File: rtl/shift_mux_pipe.sv
// -----------------------------------------------------------------------------
// shift_mux_pipe
//
// Pipelined barrel shifter / bit selector. A WIDTH-bit word is shifted by
// 0..WIDTH-1 positions in one of four modes; the full shifted word and its
// LSB (the selected bit) are presented on the output. The shift is split over
// SHW = log2(WIDTH) registered stages, stage k applying a shift of 2^k when
// bit k of the amount is set. Valid/ready handshakes on both sides; all
// stages advance together, so a stalled consumer freezes the whole pipe.
//
// Parameters
//   WIDTH     data width, power of two, >= 2
//   SHW       shift-amount width and stage count (derived, do not override)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      input accepted this cycle (combinational)
//   in_data    in   WIDTH  word to shift
//   in_amt     in   SHW    shift amount 0..WIDTH-1
//   in_mode    in   2      00 lsr, 01 lsl, 10 asr, 11 ror
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts the result
//   out_data   out  WIDTH  shifted word
//   out_bit    out  1      out_data[0]
// -----------------------------------------------------------------------------
module shift_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_bit
);

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  // Everything a word needs to finish its journey down the pipe. The sign
  // bit is the MSB of the original input word, so arithmetic fill stays
  // correct however the amount is decomposed.
  typedef struct packed {
    logic             valid;
    logic             sign;
    mode_e            mode;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t r_stage [SHW];  // registered stage contents
  stage_t w_src   [SHW];  // what each stage sees at its input
  stage_t w_next  [SHW];  // each stage input after its conditional shift
  logic   w_adv;

  // Shift by a fixed distance sh in the given mode. Indices are taken modulo
  // WIDTH through the SHW-bit cast, which is exact because WIDTH is a power
  // of two; the range tests pick fill bits where the source falls off.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input int               sh,
    input mode_e            mode,
    input logic             sign
  );
    logic [WIDTH-1:0] res;
    logic [SHW-1:0]   idx_r;
    logic [SHW-1:0]   idx_l;
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx_r = SHW'(i + sh);
      idx_l = SHW'(i - sh);
      case (mode)
        MODE_LSR: res[i] = (i + sh < WIDTH) ? d[idx_r] : 1'b0;
        MODE_LSL: res[i] = (i >= sh)        ? d[idx_l] : 1'b0;
        MODE_ASR: res[i] = (i + sh < WIDTH) ? d[idx_r] : sign;
        MODE_ROR: res[i] = d[idx_r];
        default:  res[i] = d[i];
      endcase
    end
    return res;
  endfunction

  // One global advance: the pipe moves only when the last stage is empty or
  // being drained, which gives full throughput without internal skid buffers.
  assign w_adv    = !r_stage[SHW-1].valid || out_ready;
  assign in_ready = w_adv;

  // Stage inputs. A bubble loads all zeros so idle stages carry no stale
  // payload; input fields are ignored unless a transfer happens.
  always_comb begin
    // NOTE: every variable written here gets a value on every path first,
    // otherwise the tool infers latches for the paths left unassigned.
    for (int k = 0; k < SHW; k++) begin
      w_src[k] = '0;
    end
    if (in_valid) begin
      w_src[0] = '{valid: 1'b1,
                   sign:  in_data[WIDTH-1],
                   mode:  mode_e'(in_mode),
                   amt:   in_amt,
                   data:  in_data};
    end
    for (int k = 1; k < SHW; k++) begin
      w_src[k] = r_stage[k-1];
    end
  end

  // Stage k consumes amount bit k and clears it, so the amount field holds
  // the remaining shift as the word travels.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      w_next[k] = w_src[k];
      if (w_src[k].amt[k]) begin
        w_next[k].data   = shift_step(w_src[k].data, 1 << k,
                                      w_src[k].mode, w_src[k].sign);
        w_next[k].amt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with the valid bits so
      // that out_data reads zero after reset rather than a stale word.
      for (int k = 0; k < SHW; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_adv) begin
      // NOTE: non-blocking assignment makes every stage sample the previous
      // stage's old value, which is what turns this loop into a pipeline.
      for (int k = 0; k < SHW; k++) begin
        r_stage[k] <= w_next[k];
      end
    end
  end

  assign out_valid = r_stage[SHW-1].valid;
  assign out_data  = r_stage[SHW-1].data;
  assign out_bit   = r_stage[SHW-1].data[0];

endmodule

// File: tb/tb_shift_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_mux_pipe
//
// Directed bench for shift_mux_pipe at WIDTH=8. Inputs are driven on the
// falling clock edge and outputs sampled 1 ns later, well away from the
// rising edge where the DUT registers update.
// -----------------------------------------------------------------------------
module tb_shift_mux_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int N_RAND = 10000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_bit;

  int checks = 0;
  int errors = 0;

  shift_mux_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bit   (out_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Straight single-step reference shift.
  function automatic logic [7:0] ref_shift(input logic [7:0] d,
                                           input logic [2:0] a,
                                           input logic [1:0] m);
    logic signed [7:0] s;
    s = d;
    case (m)
      2'b00:   return d >> a;
      2'b01:   return d << a;
      2'b10:   return s >>> a;
      default: return (d >> a) | (d << (4'd8 - {1'b0, a}));
    endcase
  endfunction

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out_data: got %h want 00", out_data);
    end
    checks++;
    if (out_bit !== 1'b0) begin
      errors++; $display("FAIL reset_out_bit: got %b want 0", out_bit);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // Send one word into an idle pipe and check latency and result.
  task automatic send_one(input logic [7:0] d, input logic [2:0] a,
                          input logic [1:0] m, input logic [7:0] exp,
                          input string name);
    int  lat;
    bit  got;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    lat = 0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'hEE;
      #1;
      lat++;
      if (out_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s_timeout: got no out_valid want latency 3", name);
    end else begin
      checks++;
      if (lat != 3) begin
        errors++; $display("FAIL %s_latency: got %0d want 3", name, lat);
      end
      checks++;
      if (out_data !== exp) begin
        errors++; $display("FAIL %s_data: got %h want %h", name, out_data, exp);
      end
      checks++;
      if (out_bit !== exp[0]) begin
        errors++; $display("FAIL %s_bit: got %b want %b", name, out_bit, exp[0]);
      end
    end
  endtask

  task automatic test_basic();
    send_one(8'h02, 3'd1, 2'b00, 8'h01, "basic_lsr");
  endtask

  task automatic test_modes();
    send_one(8'h01, 3'd7, 2'b01, 8'h80, "mode_lsl");
    send_one(8'h80, 3'd7, 2'b10, 8'hFF, "mode_asr");
    send_one(8'h81, 3'd4, 2'b11, 8'h18, "mode_ror");
    send_one(8'h4C, 3'd3, 2'b10, 8'h09, "mode_asr_pos");
    for (int m = 0; m < 4; m++) begin
      send_one(8'hA5, 3'd0, 2'(m), 8'hA5, "mode_amt0");
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int rcv;
    int stall_left;
    bit started;
    sent = 0; rcv = 0; stall_left = 0; started = 0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      @(negedge clk);
      out_ready = (stall_left == 0);
      in_valid  = (sent < 8);
      in_data   = 8'(sent + 1);
      in_amt    = 3'd0;
      in_mode   = 2'b00;
      #1;
      if (!out_ready && out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_in_ready_drop: got %b want 0", in_ready);
        end
        checks++;
        if (out_data !== 8'(rcv + 1)) begin
          errors++; $display("FAIL b2b_hold: got %h want %h", out_data, 8'(rcv + 1));
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 8'(rcv + 1)) begin
          errors++; $display("FAIL b2b_order: got %h want %h", out_data, 8'(rcv + 1));
        end
        rcv++;
      end
      if (!out_ready) stall_left--;
      if (out_valid && !started) begin
        started    = 1;
        stall_left = 5;
      end
    end
    checks++;
    if (rcv != 8) begin
      errors++; $display("FAIL b2b_count: got %0d words want 8", rcv);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_no_repeat: got out_valid %b data %h want 0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_sparse();
    bit in_hist [24];
    bit out_hist[24];
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 12) && (c % 2 == 0);
      in_data   = 8'(c * 17 + 3);
      in_amt    = 3'(c);
      in_mode   = 2'(c);
      #1;
      in_hist[c]  = in_valid && in_ready;
      out_hist[c] = out_valid;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_hist[c] !== 1'b0) begin
        errors++; $display("FAIL sparse_head[%0d]: got %b want 0", c, out_hist[c]);
      end
    end
    for (int c = 0; c < 21; c++) begin
      checks++;
      if (out_hist[c+3] !== in_hist[c]) begin
        errors++; $display("FAIL sparse_pattern[%0d]: got %b want %b", c + 3, out_hist[c+3], in_hist[c]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'(8'h11 * (i + 1));
      in_amt    = 3'd0;
      in_mode   = 2'b00;
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++; $display("FAIL rst_pre: got valid %b data %h want 1 11", out_valid, out_data);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL rst_async_data: got %h want 00", out_data);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_no_ghost: got valid %b data %h want 0", out_valid, out_data);
      end
    end
    send_one(8'h5A, 3'd0, 2'b00, 8'h5A, "rst_next");
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] exp;
    logic [7:0] prev_data;
    bit         prev_stall;
    int         sent;
    int         cyc;
    sent = 0; cyc = 0; prev_stall = 0; prev_data = '0;
    while ((sent < N_RAND || exp_q.size() != 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL rand_hold: got valid %b data %h want 1 %h", out_valid, out_data, prev_data);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, in_amt, in_mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %h want no word", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp || out_bit !== exp[0]) begin
            errors++; $display("FAIL rand_data: got %h/%b want %h/%b", out_data, out_bit, exp, exp[0]);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    checks++;
    if (sent != N_RAND || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_timeout: got sent %0d pending %0d want %0d 0", sent, exp_q.size(), N_RAND);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_back_to_back();
    test_sparse();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
